// File: rtl/uart_cmd_initiator.sv
// uart_cmd_initiator: sends a memory-write frame in decimal ASCII over uart_basic and checks the reply
module uart_cmd_initiator #(
    parameter int ADDR_W = 10,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_dout,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);
    localparam logic [2:0] S_IDLE = 3'd0, S_HDR = 3'd1, S_FETCH = 3'd2, S_LOAD = 3'd3,
                           S_DIGITS = 3'd4, S_END = 3'd5, S_RESP = 3'd6, S_RESP_LF = 3'd7;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [2:0] state;
    logic [1:0] idx;
    logic guard, pend, want, abort, to_hit;
    logic [7:0] data_q, hun, ten, one, byte_sel;
    logic [ADDR_W:0] len_q, count;
    logic [TW-1:0] tcnt;
    always_comb begin
        hun = data_q / 8'd100;
        ten = (data_q / 8'd10) % 8'd10;
        one = data_q % 8'd10;
        byte_sel = state == S_END ? 8'h24 :
                   state == S_DIGITS ? (idx == 2'd0 ? 8'h30 + hun : idx == 2'd1 ? 8'h30 + ten :
                                        idx == 2'd2 ? 8'h30 + one : 8'h0a) :
                   (idx == 2'd0 ? 8'h40 : idx == 2'd1 ? 8'h77 : idx == 2'd2 ? 8'h61 : 8'h0a);
        abort = rx_ready && rx_data == 8'h45 && state inside {S_HDR, S_FETCH, S_LOAD, S_DIGITS, S_END};
        want = state inside {S_HDR, S_DIGITS, S_END} && !abort;
        // the cycle after a start is a guard: tx_busy may not have risen yet
        tx_start = want && !guard && !tx_busy;
        tx_data = tx_start ? byte_sel : 8'h00;
        mem_en = state == S_FETCH;
        // registered error lands TIMEOUT_CYCLES after the "$" start cycle
        to_hit = tcnt == TW'(TIMEOUT_CYCLES - 2);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx <= '0;
            guard <= 1'b0;
            pend <= 1'b0;
            data_q <= '0;
            len_q <= '0;
            count <= '0;
            tcnt <= '0;
            mem_addr <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            err_code <= 2'd0;
        end else begin
            done <= 1'b0;
            error <= 1'b0;
            guard <= tx_start;
            if (state == S_RESP || state == S_RESP_LF) tcnt <= tcnt + 1'b1;
            if (abort) begin
                pend <= 1'b1;
                state <= S_RESP_LF;
            end else begin
                case (state)
                    S_IDLE: if (start && !done && !error) begin
                        len_q <= len;
                        err_code <= 2'd0;
                        busy <= 1'b1;
                        idx <= '0;
                        count <= '0;
                        tcnt <= '0;
                        mem_addr <= '0;
                        state <= S_HDR;
                    end
                    S_HDR: if (tx_start) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) state <= len_q == '0 ? S_END : S_FETCH;
                    end
                    S_FETCH: state <= S_LOAD;
                    S_LOAD: begin
                        data_q <= mem_dout;
                        idx <= mem_dout >= 8'd100 ? 2'd0 : mem_dout >= 8'd10 ? 2'd1 : 2'd2;
                        state <= S_DIGITS;
                    end
                    S_DIGITS: if (tx_start) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            mem_addr <= mem_addr + 1'b1;
                            count <= count + 1'b1;
                            state <= count + 1'b1 == len_q ? S_END : S_FETCH;
                        end
                    end
                    S_END: if (tx_start) begin
                        tcnt <= '0;
                        state <= S_RESP;
                    end
                    S_RESP: if (rx_ready) begin
                        if (rx_data == 8'h44 || rx_data == 8'h45) begin
                            pend <= rx_data == 8'h45;
                            state <= S_RESP_LF;
                        end else begin
                            error <= 1'b1;
                            err_code <= 2'd3;
                            busy <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else if (to_hit) begin
                        error <= 1'b1;
                        err_code <= 2'd2;
                        busy <= 1'b0;
                        state <= S_IDLE;
                    end
                    S_RESP_LF: if (rx_ready) begin
                        error <= rx_data != 8'h0a || pend;
                        done <= rx_data == 8'h0a && !pend;
                        err_code <= rx_data != 8'h0a ? 2'd3 : pend ? 2'd1 : 2'd0;
                        busy <= 1'b0;
                        state <= S_IDLE;
                    end else if (to_hit) begin
                        error <= 1'b1;
                        err_code <= 2'd2;
                        busy <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_initiator.sv
// tb_uart_cmd_initiator: directed frames against a BRAM/transmitter model with a scoreboard monitor
module tb_uart_cmd_initiator;
    localparam int AW = 4;
    localparam int TO = 1000;
    logic clk = 0, rst_n = 0, start = 0;
    logic [AW:0] len = '0;
    logic mem_en, tx_start, tx_busy, busy, done, error;
    logic [AW-1:0] mem_addr;
    logic [7:0] mem_dout = '0, tx_data, rx_data = '0;
    logic rx_ready = 0;
    logic [1:0] err_code;
    uart_cmd_initiator #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_ready(rx_ready), .busy(busy), .done(done), .error(error),
        .err_code(err_code));
    always #5 clk = ~clk;
    logic [7:0] mem [16];
    always @(posedge clk) if (mem_en) mem_dout <= mem[mem_addr];
    // transmitter whose busy flag rises only two cycles after the request
    logic tx_pend = 0, hold = 0;
    int tx_cnt = 0;
    always @(posedge clk) begin
        tx_pend <= tx_start;
        tx_cnt <= tx_pend ? 10 : (tx_cnt > 0 ? tx_cnt - 1 : 0);
    end
    assign tx_busy = hold || tx_cnt != 0;
    typedef struct {bit err; bit [1:0] code; int lat;} ev_t;
    ev_t exp_ev[$];
    ev_t mon_e;
    logic [7:0] exp_tx[$];
    int n_cmp = 0, n_bad = 0, cyc = 0, tx_seen = 0, ev_seen = 0, dollar_cyc = 0;
    bit prev_tx = 0;
    logic [7:0] v1 [13] = '{8'h40, 8'h77, 8'h61, 8'h0a, 8'h30, 8'h0a, 8'h37, 8'h0a, 8'h32, 8'h35, 8'h35, 8'h0a, 8'h24};
    logic [7:0] v5 [10] = '{8'h40, 8'h77, 8'h61, 8'h0a, 8'h35, 8'h0a, 8'h31, 8'h32, 8'h33, 8'h0a};
    logic [7:0] vr [6]  = '{8'h40, 8'h77, 8'h61, 8'h0a, 8'h32, 8'h30};
    logic [7:0] v42 [8] = '{8'h40, 8'h77, 8'h61, 8'h0a, 8'h34, 8'h32, 8'h0a, 8'h24};
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic miss(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event absent or unexpected at cycle %0d", nm, cyc);
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_start) begin
                tx_seen++;
                chk("tx_guard", prev_tx, 0);
                chk("tx_while_busy", tx_busy, 0);
                if (exp_tx.size() == 0) miss("tx_unexpected");
                else chk("tx_byte", tx_data, exp_tx.pop_front());
                if (tx_data == 8'h24) dollar_cyc = cyc;
            end
            prev_tx = tx_start;
            if (done || error) begin
                ev_seen++;
                if (exp_ev.size() == 0) miss("ev_unexpected");
                else begin
                    mon_e = exp_ev.pop_front();
                    chk("ev_error", error, mon_e.err);
                    chk("ev_done", done, !mon_e.err);
                    chk("ev_code", err_code, mon_e.code);
                    chk("ev_busy", busy, 0);
                    if (mon_e.lat >= 0) chk("ev_latency", cyc - dollar_cyc, mon_e.lat);
                end
            end
        end
    end
    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1 rx_data = b; rx_ready = 1;
        @(posedge clk); #1 rx_ready = 0;
    endtask
    task automatic do_start(input int l);
        @(posedge clk); #1 start = 1; len = (AW+1)'(l);
        @(posedge clk); #1 start = 0;
    endtask
    task automatic wait_drain();
        for (int i = 0; i < 5000 && exp_tx.size() != 0; i++) @(negedge clk);
        if (exp_tx.size() != 0) miss("drain_timeout");
    endtask
    task automatic wait_tx(input int n);
        for (int i = 0; i < 5000 && tx_seen < n; i++) @(negedge clk);
        if (tx_seen < n) miss("wait_tx_timeout");
    endtask
    task automatic wait_ev(input int n, input int budget);
        for (int i = 0; i < budget && ev_seen < n; i++) @(negedge clk);
        if (ev_seen < n) miss("wait_ev_timeout");
    endtask
    task automatic push_ev(input bit err, input bit [1:0] code, input int lat);
        ev_t e;
        e.err = err; e.code = code; e.lat = lat;
        exp_ev.push_back(e);
    endtask
    task automatic push_frame(input int l);
        string s;
        exp_tx.push_back(8'h40); exp_tx.push_back(8'h77); exp_tx.push_back(8'h61); exp_tx.push_back(8'h0a);
        for (int i = 0; i < l; i++) begin
            s = $sformatf("%0d", mem[i]);
            for (int j = 0; j < s.len(); j++) exp_tx.push_back(s[j]);
            exp_tx.push_back(8'h0a);
        end
        exp_tx.push_back(8'h24);
    endtask
    initial begin
        int b, n;
        for (int i = 0; i < 16; i++) mem[i] = 0;
        #2;
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_error", {done, error}, 0);
        chk("rst_err_code", err_code, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        mem[0] = 0; mem[1] = 7; mem[2] = 255;
        foreach (v1[i]) exp_tx.push_back(v1[i]);
        push_ev(0, 0, -1);
        do_start(3);
        do_start(0);
        chk("busy_during", busy, 1);
        wait_drain();
        send_rx(8'h44); send_rx(8'h0a);
        chk("done_timing", done, 1);
        wait_ev(1, 100);
        @(posedge clk); #1;
        chk("busy_after", busy, 0);
        chk("err_code_ok", err_code, 0);
        push_frame(0); push_ev(0, 0, -1);
        do_start(0); wait_drain();
        send_rx(8'h44); send_rx(8'h0a); wait_ev(2, 100);
        mem[0] = 12; mem[1] = 99;
        push_frame(2); push_ev(1, 1, -1);
        do_start(2); wait_drain();
        send_rx(8'h45); send_rx(8'h0a); wait_ev(3, 100);
        repeat (5) @(posedge clk);
        chk("err_code_held", err_code, 1);
        mem[0] = 100;
        push_frame(1); push_ev(1, 2, TO);
        do_start(1); wait_drain(); wait_ev(4, 3000);
        send_rx(8'h44); send_rx(8'h0a);
        repeat (20) @(posedge clk);
        chk("late_reply_ignored", ev_seen, 4);
        chk("late_busy", busy, 0);
        chk("timeout_code_held", err_code, 2);
        push_frame(0); push_ev(1, 3, -1);
        do_start(0); wait_drain();
        send_rx(8'h58); wait_ev(5, 100);
        mem[0] = 5; mem[1] = 123; mem[2] = 9; mem[3] = 8; mem[4] = 7;
        b = tx_seen;
        foreach (v5[i]) exp_tx.push_back(v5[i]);
        push_ev(1, 1, -1);
        do_start(5); wait_tx(b + 2);
        hold = 1; n = 0;
        repeat (500) @(negedge clk) if (tx_start) n++;
        hold = 0;
        chk("hold_no_tx", n, 0);
        wait_tx(b + 10);
        send_rx(8'h45);
        repeat (60) @(posedge clk);
        chk("abort_no_tx", tx_seen, b + 10);
        chk("abort_busy", busy, 1);
        send_rx(8'h0a); wait_ev(6, 100);
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);
        push_frame(16); push_ev(0, 0, -1);
        do_start(16); wait_drain();
        send_rx(8'h44); send_rx(8'h0a); wait_ev(7, 100);
        chk("wrap_addr", mem_addr, 0);
        mem[0] = 200;
        b = tx_seen;
        foreach (vr[i]) exp_tx.push_back(vr[i]);
        do_start(1); wait_tx(b + 5);
        @(posedge clk);
        for (int i = 0; i < 200 && !tx_start; i++) @(negedge clk);
        #1 chk("pre_reset_tx", tx_seen, b + 6);
        rst_n = 0;
        #1;
        chk("reset_tx_start", tx_start, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err_code", err_code, 0);
        chk("reset_mem_en", mem_en, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        mem[0] = 42;
        foreach (v42[i]) exp_tx.push_back(v42[i]);
        push_ev(0, 0, -1);
        do_start(1); wait_drain();
        send_rx(8'h44); send_rx(8'h0a); wait_ev(8, 100);
        repeat (5) @(posedge clk);
        chk("tx_queue_empty", exp_tx.size(), 0);
        chk("ev_queue_empty", exp_ev.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
